// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// Radix-2 shift-add multiply and restoring divide, one result bit per cycle,
// sharing a single WIDTH+1-bit adder. Divide-by-zero and signed overflow
// complete on the accept edge without iterating.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             StartE,
  input  logic             FlushE,
  input  logic [2:0]       OpE,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BusyE,
  output logic             DoneE,
  output logic [WIDTH-1:0] ResultE,
  output logic [1:0]       Flags
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_FIX,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  // Multiply: {hi, lo} product with the multiplier shifting out of lo.
  // Divide:   {rem, quo} with the dividend shifting into rem.
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  // Multiplicand for multiply, divisor for divide.
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic                 negres_q, negres_d;
  logic                 negrem_q, negrem_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [1:0]           flags_q, flags_d;

  // Accept-time operand decode
  op_e                  op_in;
  logic                 a_sgn, b_sgn, a_neg, b_neg;
  logic [WIDTH-1:0]     a_abs, b_abs;
  logic                 in_is_div, div_zero, div_ovf;
  logic [WIDTH-1:0]     fast_res;

  // Shared adder
  logic [WIDTH:0]       add_a, add_b;
  logic                 add_cin;
  logic [WIDTH:0]       add_sum;
  logic                 add_co;
  logic [2*WIDTH-1:0]   iter_prod;

  // Final sign fix-up
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix, fix_res;

  assign op_in = op_e'(OpE);

  // Operand signedness, magnitudes and fast-path detection for a new request
  always_comb begin
    a_sgn     = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                (op_in == OP_DIV)  || (op_in == OP_REM);
    b_sgn     = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    a_neg     = a_sgn & A[WIDTH-1];
    b_neg     = b_sgn & B[WIDTH-1];
    a_abs     = a_neg ? -A : A;
    b_abs     = b_neg ? -B : B;
    in_is_div = OpE[2];
    div_zero  = in_is_div && (B == '0);
    div_ovf   = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                (A == MIN_NEG) && (B == '1);
    fast_res  = '0;
    if (div_zero) begin
      fast_res = OpE[1] ? A : '1;
    end else if (div_ovf) begin
      fast_res = OpE[1] ? '0 : A;
    end
  end

  // One multiply or divide step through the shared adder
  always_comb begin
    if (op_q[2]) begin
      add_a   = prod_q[2*WIDTH-1:WIDTH-1];
      add_b   = ~{1'b0, mcand_q};
      add_cin = 1'b1;
    end else begin
      add_a   = {1'b0, prod_q[2*WIDTH-1:WIDTH]};
      add_b   = {1'b0, mcand_q};
      add_cin = 1'b0;
    end
    {add_co, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, add_cin};

    if (op_q[2]) begin
      // Carry out of the trial subtraction means no borrow: keep the difference.
      iter_prod = add_co ? {add_sum[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1}
                         : {prod_q[2*WIDTH-2:0], 1'b0};
    end else begin
      iter_prod = prod_q[0] ? {add_sum, prod_q[WIDTH-1:1]}
                            : {1'b0, prod_q[2*WIDTH-1:1]};
    end
  end

  // Sign correction and result selection for the FIX cycle
  always_comb begin
    prod_fix = negres_q ? -prod_q : prod_q;
    quo_fix  = negres_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
    rem_fix  = negrem_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
    case (op_q)
      OP_MUL:                      fix_res = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:             fix_res = quo_fix;
      default:                     fix_res = rem_fix;
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    negres_d = negres_q;
    negrem_d = negrem_q;
    result_d = result_q;
    flags_d  = flags_q;

    case (state_q)
      S_IDLE: begin
        if (StartE) begin
          op_d = op_in;
          if (div_zero || div_ovf) begin
            result_d = fast_res;
            flags_d  = {div_zero, div_ovf & ~div_zero};
            state_d  = S_DONE;
          end else begin
            cnt_d    = CNT_W'(WIDTH);
            negres_d = a_neg ^ b_neg;
            negrem_d = a_neg;
            if (in_is_div) begin
              prod_d  = {{WIDTH{1'b0}}, a_abs};
              mcand_d = b_abs;
            end else begin
              prod_d  = {{WIDTH{1'b0}}, b_abs};
              mcand_d = a_abs;
            end
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        prod_d = iter_prod;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = fix_res;
        flags_d  = '0;
        state_d  = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything above, including an accept in IDLE.
    if (FlushE) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      op_d     = op_q;
      prod_d   = prod_q;
      mcand_d  = mcand_q;
      negres_d = negres_q;
      negrem_d = negrem_q;
      result_d = result_q;
      flags_d  = flags_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MUL;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      negres_q <= 1'b0;
      negrem_q <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      negres_q <= negres_d;
      negrem_q <= negrem_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign BusyE   = (state_q == S_BUSY) || (state_q == S_FIX);
  assign DoneE   = (state_q == S_DONE);
  assign ResultE = result_q;
  assign Flags   = flags_q;

endmodule
